// File: rtl/pe_conv_seq_pkg.sv
// Shared types and sizes for the single-PE 2x2 convolution engine.
// Operand/accumulator widths, tap and window counts, FSM state encoding.
package conv_pkg;

    localparam int DATA_W   = 8;
    localparam int ACC_W    = 20;
    localparam int NUM_TAPS = 9;
    localparam int NUM_WIN  = 4;
    localparam int NUM_PIX  = 16;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        STORE,
        DONE
    } state_t;

endpackage

// File: rtl/pe_conv_seq_if.sv
// Operand, control and result bundle between pe_conv_seq and its neighbours.
// master: drives start/a*/b*; slave (the engine) drives results and strobes.
interface pe_conv_seq_if;
    import conv_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a11, a12, a13, a14;
    logic [DATA_W-1:0] a21, a22, a23, a24;
    logic [DATA_W-1:0] a31, a32, a33, a34;
    logic [DATA_W-1:0] a41, a42, a43, a44;
    logic [DATA_W-1:0] b11, b12, b13;
    logic [DATA_W-1:0] b21, b22, b23;
    logic [DATA_W-1:0] b31, b32, b33;
    logic [DATA_W-1:0] PE_result;
    logic [ACC_W-1:0]  result_full;
    logic              C11_PE, C12_PE;
    logic              C21_PE, C22_PE;
    logic              busy, done;

    modport master (
        output start,
        output a11, a12, a13, a14,
        output a21, a22, a23, a24,
        output a31, a32, a33, a34,
        output a41, a42, a43, a44,
        output b11, b12, b13,
        output b21, b22, b23,
        output b31, b32, b33,
        input  PE_result, result_full,
        input  C11_PE, C12_PE,
        input  C21_PE, C22_PE,
        input  busy, done
    );

    modport slave (
        input  start,
        input  a11, a12, a13, a14,
        input  a21, a22, a23, a24,
        input  a31, a32, a33, a34,
        input  a41, a42, a43, a44,
        input  b11, b12, b13,
        input  b21, b22, b23,
        input  b31, b32, b33,
        output PE_result, result_full,
        output C11_PE, C12_PE,
        output C21_PE, C22_PE,
        output busy, done
    );

endinterface

// File: rtl/pe_conv_seq_mac.sv
// Registered unsigned multiply-accumulate for the convolution PE.
// Ports: clk, rst_n, clr_load (load product), en, x, w, acc.
module pe_mac
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_load,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    assign prod     = x * w;
    assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= clr_load ? prod_ext : acc + prod_ext;
        end
    end

endmodule

// File: rtl/pe_conv_seq.sv
// Sequential 2x2 valid convolution of a 4x4 image with a 3x3 filter on one MAC.
// Ports: clk, rst_n, bus (slave: start/a*/b* in; PE_result/result_full/C*_PE/busy/done out).
module pe_conv_seq
    import conv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    pe_conv_seq_if.slave bus
);

    state_t state, state_nx;

    logic [1:0]         ti, tj, win;
    logic               tap_first, tap_last;
    logic [1:0]         row, col;
    logic [3:0]         img_idx, flt_idx;
    logic [DATA_W-1:0]  img [NUM_PIX];
    logic [DATA_W-1:0]  flt [NUM_TAPS];
    logic [ACC_W-1:0]   acc;
    logic [NUM_WIN-1:0] strb;
    logic [DATA_W-1:0]  res_q;
    logic [ACC_W-1:0]   full_q;
    logic               done_q, busy_q;

    assign img[0]  = bus.a11;
    assign img[1]  = bus.a12;
    assign img[2]  = bus.a13;
    assign img[3]  = bus.a14;
    assign img[4]  = bus.a21;
    assign img[5]  = bus.a22;
    assign img[6]  = bus.a23;
    assign img[7]  = bus.a24;
    assign img[8]  = bus.a31;
    assign img[9]  = bus.a32;
    assign img[10] = bus.a33;
    assign img[11] = bus.a34;
    assign img[12] = bus.a41;
    assign img[13] = bus.a42;
    assign img[14] = bus.a43;
    assign img[15] = bus.a44;

    assign flt[0] = bus.b11;
    assign flt[1] = bus.b12;
    assign flt[2] = bus.b13;
    assign flt[3] = bus.b21;
    assign flt[4] = bus.b22;
    assign flt[5] = bus.b23;
    assign flt[6] = bus.b31;
    assign flt[7] = bus.b32;
    assign flt[8] = bus.b33;

    assign tap_first = (ti == 2'd0) && (tj == 2'd0);
    assign tap_last  = (ti == 2'd2) && (tj == 2'd2);

    // Image row/col never exceed 3, so {row,col} is the row-major index.
    assign row     = {1'b0, win[1]} + ti;
    assign col     = {1'b0, win[0]} + tj;
    assign img_idx = {row, col};
    assign flt_idx = {1'b0, ti, 1'b0} + {2'b00, ti} + {2'b00, tj};

    pe_mac u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_load (tap_first),
        .en       (state == MAC),
        .x        (img[img_idx]),
        .w        (flt[flt_idx]),
        .acc      (acc)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.start) state_nx = MAC;
            MAC:   if (tap_last) state_nx = STORE;
            STORE: state_nx = (win == 2'd3) ? DONE : MAC;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ti  <= '0;
            tj  <= '0;
            win <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        ti  <= '0;
                        tj  <= '0;
                        win <= '0;
                    end
                end
                MAC: begin
                    if (tj == 2'd2) begin
                        tj <= '0;
                        ti <= tap_last ? 2'd0 : ti + 2'd1;
                    end else begin
                        tj <= tj + 2'd1;
                    end
                end
                STORE: win <= win + 2'd1;
                DONE:  win <= '0;
            endcase
        end
    end

    // busy covers the whole run including the done cycle; it is only
    // released on the edge after done unless a new start lands there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb   <= '0;
            res_q  <= '0;
            full_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            strb   <= '0;
            done_q <= (state == DONE);
            if (state == STORE) begin
                strb   <= NUM_WIN'(1) << win;
                res_q  <= acc[DATA_W-1:0];
                full_q <= acc;
            end
            if (state == IDLE && bus.start) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.PE_result   = res_q;
    assign bus.result_full = full_q;
    assign bus.C11_PE      = strb[0];
    assign bus.C12_PE      = strb[1];
    assign bus.C21_PE      = strb[2];
    assign bus.C22_PE      = strb[3];
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_pe_conv_seq.sv
// Self-checking bench for pe_conv_seq: directed and random runs against
// a plain-arithmetic convolution model, with cycle-exact strobe timing.
module tb_pe_conv_seq;

    logic clk;
    logic rst_n;

    pe_conv_seq_if bus ();

    pe_conv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    bit [7:0] img [4][4];
    bit [7:0] flt [3][3];

    int exp_pe   = 0;
    int exp_full = 0;
    int got [4];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_sum(input int w);
        int r, c, s;
        r = w / 2;
        c = w % 2;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(img[r+i][c+j]) * int'(flt[i][j]);
        return s;
    endfunction

    task automatic drive_ops();
        bus.a11 = img[0][0]; bus.a12 = img[0][1];
        bus.a13 = img[0][2]; bus.a14 = img[0][3];
        bus.a21 = img[1][0]; bus.a22 = img[1][1];
        bus.a23 = img[1][2]; bus.a24 = img[1][3];
        bus.a31 = img[2][0]; bus.a32 = img[2][1];
        bus.a33 = img[2][2]; bus.a34 = img[2][3];
        bus.a41 = img[3][0]; bus.a42 = img[3][1];
        bus.a43 = img[3][2]; bus.a44 = img[3][3];
        bus.b11 = flt[0][0]; bus.b12 = flt[0][1];
        bus.b13 = flt[0][2]; bus.b21 = flt[1][0];
        bus.b22 = flt[1][1]; bus.b23 = flt[1][2];
        bus.b31 = flt[2][0]; bus.b32 = flt[2][1];
        bus.b33 = flt[2][2];
    endtask

    task automatic load_seq();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                img[i][j] = 8'(i * 4 + j + 1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                flt[i][j] = 8'(i * 3 + j + 1);
        drive_ops();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_str"}, {bus.C22_PE, bus.C21_PE, bus.C12_PE, bus.C11_PE}, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_pe"}, bus.PE_result, exp_pe);
        chk({tag, "_full"}, bus.result_full, exp_full);
    endtask

    // One 42-cycle run from start sample E0. hold keeps start high for a
    // back-to-back run; pulse pokes start at E5/E25 while busy.
    task automatic run_one(input bit hold, input bit pulse);
        int w, last;
        logic [3:0] es;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = hold;
        chk("busy_e0", bus.busy, 1);
        last = hold ? 41 : 42;
        for (int k = 1; k <= last; k++) begin
            if (pulse) bus.start = (k == 5 || k == 25);
            @(posedge clk);
            #1;
            es = (k == 10) ? 4'b0001 :
                 (k == 20) ? 4'b0010 :
                 (k == 30) ? 4'b0100 :
                 (k == 40) ? 4'b1000 : 4'b0000;
            chk($sformatf("strobe_e%0d", k),
                {bus.C22_PE, bus.C21_PE, bus.C12_PE, bus.C11_PE}, es);
            if (es != 0) begin
                w = k / 10 - 1;
                exp_full = ref_sum(w);
                exp_pe = exp_full % 256;
                got[w] = bus.result_full;
            end
            chk($sformatf("pe_e%0d", k), bus.PE_result, exp_pe);
            chk($sformatf("full_e%0d", k), bus.result_full, exp_full);
            chk($sformatf("done_e%0d", k), bus.done, (k == 41));
            chk($sformatf("busy_e%0d", k), bus.busy, (k <= 41));
        end
        bus.start = hold;
    endtask

    task automatic check_t2(input string tag);
        chk({tag, "_c11"}, got[0], 348);
        chk({tag, "_c12"}, got[1], 393);
        chk({tag, "_c21"}, got[2], 528);
        chk({tag, "_c22"}, got[3], 573);
        chk({tag, "_last_pe"}, bus.PE_result, 61);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        load_seq();

        // T1: outputs cleared while reset is held
        #12;
        check_idle("t1");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("t1_rel");

        // T2: sequential operands
        run_one(1'b0, 1'b0);
        check_t2("t2");

        // T3: all-ones operands, no overflow
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                img[i][j] = 8'd255;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                flt[i][j] = 8'd255;
        drive_ops();
        run_one(1'b0, 1'b0);
        for (int w = 0; w < 4; w++)
            chk($sformatf("t3_full%0d", w), got[w], 585225);
        chk("t3_pe", bus.PE_result, 9);

        // Random operand runs
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    img[i][j] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    flt[i][j] = 8'($urandom_range(0, 255));
            drive_ops();
            run_one(1'b0, 1'b0);
        end

        // T4: start pulses during a run are ignored
        load_seq();
        run_one(1'b0, 1'b1);
        check_t2("t4");

        // T5: reset mid-run aborts cleanly
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("t5_pre_busy", bus.busy, 1);
        chk("t5_pre_pe", bus.PE_result, 92);
        rst_n = 1'b0;
        #1;
        exp_pe   = 0;
        exp_full = 0;
        check_idle("t5_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("t5_quiet%0d", k));
        end
        run_one(1'b0, 1'b0);
        check_t2("t5");

        // T6: start held high, back-to-back runs
        for (int n = 0; n < 3; n++) begin
            run_one(1'b1, 1'b0);
            check_t2($sformatf("t6_%0d", n));
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_idle("t6_end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
